mmio_master: RTL and testbench

Single-outstanding MMIO bus master between the CPU memory stage and the peripheral MMIO bus (LED, future UART/timer). It accepts one CPU load/store at a time and decodes it against the MMIO window. It issues a single-cycle `mmio_req` to the peripherals and waits for the OR-combined `mmio_done`, with a timeout. It then returns a one-cycle completion, with read data and an error flag, to the CPU.

---
 rtl/mmio_master.sv | 138 +++++++++++++
 tb/tb_mmio_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_master.sv
// mmio_master: single-outstanding bridge from the CPU memory stage to the MMIO peripheral bus.
// Latency: MMIO load/store completes in 3 cycles with a registered responder, timeout in TIMEOUT+2 cycles, non-MMIO error in 1 cycle.
// Backpressure: only one access is in flight; cpu_busy is high until the cpu_ready pulse, and cpu_req is ignored while busy.
module mmio_master #(
  parameter logic [15:0] MMIO_BASE = 16'hF000,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_ready,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_err,
  output logic        mmio_req,
  output logic        mmio_we,
  output logic [15:0] mmio_addr,
  output logic [7:0]  mmio_data,
  input  logic        mmio_done,
  input  logic [7:0]  mmio_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Last WAIT count before giving up; the counter never reaches past this value.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] LP_ERR_DATA = 8'hFF;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_busy;
  logic        r_ready;
  logic [7:0]  r_rdata;
  logic        r_err;
  logic        r_mreq;
  logic        r_mwe;
  logic [15:0] r_maddr;
  logic [7:0]  r_mdata;

  logic        w_is_mmio;
  logic        w_cnt_last;

  assign w_is_mmio  = (cpu_addr >= MMIO_BASE);
  assign w_cnt_last = (r_cnt == LP_CNT_LAST);

  assign cpu_busy  = r_busy;
  assign cpu_ready = r_ready;
  assign cpu_rdata = r_rdata;
  assign cpu_err   = r_err;
  assign mmio_req  = r_mreq;
  assign mmio_we   = r_mwe;
  assign mmio_addr = r_maddr;
  assign mmio_data = r_mdata;

  // Transaction FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_rdata <= 8'd0;
      r_err   <= 1'b0;
      r_mreq  <= 1'b0;
      r_mwe   <= 1'b0;
      r_maddr <= 16'd0;
      r_mdata <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_busy <= 1'b1;
            if (w_is_mmio) begin
              // Bus fields are latched here and held until the next accepted MMIO access.
              r_mwe   <= cpu_we;
              r_maddr <= cpu_addr;
              r_mdata <= cpu_wdata;
              r_mreq  <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              // Outside the window: fail immediately without touching the bus.
              r_rdata <= LP_ERR_DATA;
              r_err   <= 1'b1;
              r_ready <= 1'b1;
              r_state <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          r_mreq <= 1'b0;
          r_cnt  <= 8'd0;
          if (mmio_done) begin
            // A combinational responder can answer in the request cycle itself.
            r_rdata <= mmio_rdata;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mmio_done) begin
            r_rdata <= mmio_rdata;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_RESP;
          end else if (w_cnt_last) begin
            r_rdata <= LP_ERR_DATA;
            r_err   <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          // Completion pulse lasts one cycle; a new request is sampled in the following IDLE.
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_master.sv
// Directed bench for mmio_master: store, load, timeout, non-MMIO, back-to-back,
// combinational responder and asynchronous reset mid-transaction.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mmio_master;

  logic        clock;
  logic        reset_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_busy;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        cpu_err;
  logic        mmio_req;
  logic        mmio_we;
  logic [15:0] mmio_addr;
  logic [7:0]  mmio_data;
  logic        mmio_done;
  logic [7:0]  mmio_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_master #(
    .MMIO_BASE (16'hF000),
    .TIMEOUT   (16)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_busy   (cpu_busy),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .mmio_req   (mmio_req),
    .mmio_we    (mmio_we),
    .mmio_addr  (mmio_addr),
    .mmio_data  (mmio_data),
    .mmio_done  (mmio_done),
    .mmio_rdata (mmio_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic we, input logic [15:0] addr, input logic [7:0] wd);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
  endtask

  initial begin
    reset_n    = 1'b0;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = 16'h0;
    cpu_wdata  = 8'h0;
    mmio_done  = 1'b0;
    mmio_rdata = 8'h0;

    // Reset state
    #3;
    chk("rst_busy", cpu_busy, 0);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_mreq", mmio_req, 0);
    chk("rst_maddr", mmio_addr, 0);
    #9 reset_n = 1'b1;
    tick();

    // LED store F000 <- 2A, done in cycle 2
    start(1'b1, 16'hF000, 8'h2A);          // cycle 0
    chk("st_c0_mreq", mmio_req, 0);
    tick();                                 // cycle 1
    chk("st_c1_mreq", mmio_req, 1);
    chk("st_c1_maddr", mmio_addr, 16'hF000);
    chk("st_c1_mdata", mmio_data, 8'h2A);
    chk("st_c1_mwe", mmio_we, 1);
    chk("st_c1_busy", cpu_busy, 1);
    tick();                                 // cycle 2
    chk("st_c2_mreq", mmio_req, 0);
    chk("st_c2_ready", cpu_ready, 0);
    mmio_done = 1'b1; mmio_rdata = 8'h00;
    tick();                                 // cycle 3
    chk("st_c3_ready", cpu_ready, 1);
    chk("st_c3_err", cpu_err, 0);
    chk("st_c3_rdata", cpu_rdata, 8'h00);
    chk("st_c3_busy", cpu_busy, 1);
    mmio_done = 1'b0; cpu_req = 1'b0;
    tick();                                 // cycle 4
    chk("st_c4_ready", cpu_ready, 0);
    chk("st_c4_busy", cpu_busy, 0);
    tick();                                 // cycle 5
    chk("st_c5_maddr", mmio_addr, 16'hF000);
    chk("st_c5_mdata", mmio_data, 8'h2A);
    chk("st_c5_mreq", mmio_req, 0);

    // Timeout at F010, no responder
    start(1'b0, 16'hF010, 8'h00);           // cycle 0
    for (int c = 1; c <= 17; c++) begin
      tick();
      chk($sformatf("to_c%0d_ready", c), cpu_ready, 0);
    end
    tick();                                 // cycle 18
    chk("to_c18_ready", cpu_ready, 1);
    chk("to_c18_err", cpu_err, 1);
    chk("to_c18_rdata", cpu_rdata, 8'hFF);
    cpu_req = 1'b0;
    tick();                                 // cycle 19: late done
    chk("to_c19_busy", cpu_busy, 0);
    mmio_done = 1'b1; mmio_rdata = 8'h77;
    tick();                                 // cycle 20
    mmio_done = 1'b0;
    chk("to_c20_busy", cpu_busy, 0);
    chk("to_c20_ready", cpu_ready, 0);
    chk("to_c20_mreq", mmio_req, 0);
    chk("to_c20_rdata_hold", cpu_rdata, 8'hFF);
    tick();

    // Load F001, done with 5A in cycle 4
    start(1'b0, 16'hF001, 8'h00);           // cycle 0
    tick();                                 // cycle 1
    chk("ld_c1_mreq", mmio_req, 1);
    chk("ld_c1_mwe", mmio_we, 0);
    chk("ld_c1_maddr", mmio_addr, 16'hF001);
    tick(); tick();                         // cycle 3
    chk("ld_c3_ready", cpu_ready, 0);
    tick();                                 // cycle 4
    chk("ld_c4_ready", cpu_ready, 0);
    mmio_done = 1'b1; mmio_rdata = 8'h5A;
    tick();                                 // cycle 5
    mmio_done = 1'b0; mmio_rdata = 8'h00; cpu_req = 1'b0;
    chk("ld_c5_ready", cpu_ready, 1);
    chk("ld_c5_rdata", cpu_rdata, 8'h5A);
    chk("ld_c5_err", cpu_err, 0);
    tick();

    // Non-MMIO address 1234
    start(1'b0, 16'h1234, 8'h00);           // cycle 0
    tick();                                 // cycle 1
    chk("nm_c1_ready", cpu_ready, 1);
    chk("nm_c1_err", cpu_err, 1);
    chk("nm_c1_rdata", cpu_rdata, 8'hFF);
    chk("nm_c1_mreq", mmio_req, 0);
    chk("nm_c1_busy", cpu_busy, 1);
    cpu_req = 1'b0;
    tick();                                 // cycle 2
    chk("nm_c2_mreq", mmio_req, 0);
    chk("nm_c2_busy", cpu_busy, 0);
    chk("nm_c2_maddr", mmio_addr, 16'hF001);
    tick();

    // Back-to-back stores 01 then 02, cpu_req held high
    start(1'b1, 16'hF000, 8'h01);           // cycle 0
    tick();                                 // cycle 1
    chk("bb_c1_mreq", mmio_req, 1);
    chk("bb_c1_mdata", mmio_data, 8'h01);
    tick();                                 // cycle 2
    mmio_done = 1'b1;
    tick();                                 // cycle 3
    mmio_done = 1'b0;
    chk("bb_c3_ready", cpu_ready, 1);
    cpu_wdata = 8'h02;
    tick();                                 // cycle 4
    chk("bb_c4_mreq", mmio_req, 0);
    chk("bb_c4_busy", cpu_busy, 0);
    chk("bb_c4_mdata", mmio_data, 8'h01);
    tick();                                 // cycle 5
    chk("bb_c5_mreq", mmio_req, 1);
    chk("bb_c5_mdata", mmio_data, 8'h02);
    tick();                                 // cycle 6
    chk("bb_c6_ready", cpu_ready, 0);
    mmio_done = 1'b1;
    tick();                                 // cycle 7
    mmio_done = 1'b0; cpu_req = 1'b0;
    chk("bb_c7_ready", cpu_ready, 1);
    chk("bb_c7_err", cpu_err, 0);
    tick();                                 // cycle 8
    chk("bb_c8_busy", cpu_busy, 0);
    chk("bb_c8_mreq", mmio_req, 0);

    // Combinational responder: done already high during ISSUE
    start(1'b0, 16'hFFFF, 8'h00);           // cycle 0
    tick();                                 // cycle 1
    chk("cb_c1_mreq", mmio_req, 1);
    mmio_done = 1'b1; mmio_rdata = 8'hC3;
    tick();                                 // cycle 2
    mmio_done = 1'b0; mmio_rdata = 8'h00; cpu_req = 1'b0;
    chk("cb_c2_ready", cpu_ready, 1);
    chk("cb_c2_rdata", cpu_rdata, 8'hC3);
    chk("cb_c2_err", cpu_err, 0);
    tick(); tick();

    // Asynchronous reset in cycle 3 of an unanswered access
    start(1'b1, 16'hF0AA, 8'h33);           // cycle 0
    tick();                                 // cycle 1
    tick();                                 // cycle 2
    chk("ar_c2_busy", cpu_busy, 1);
    tick();                                 // cycle 3
    #2 reset_n = 1'b0;
    #1;                                     // still before the next edge
    chk("ar_busy", cpu_busy, 0);
    chk("ar_ready", cpu_ready, 0);
    chk("ar_rdata", cpu_rdata, 0);
    chk("ar_err", cpu_err, 0);
    chk("ar_mreq", mmio_req, 0);
    chk("ar_mwe", mmio_we, 0);
    chk("ar_maddr", mmio_addr, 0);
    chk("ar_mdata", mmio_data, 0);
    cpu_req = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("ar_post_mreq", mmio_req, 0);
    chk("ar_post_busy", cpu_busy, 0);

    // Fresh store after reset completes in 3 cycles
    start(1'b1, 16'hF000, 8'h77);           // cycle 0
    tick();                                 // cycle 1
    chk("pr_c1_mreq", mmio_req, 1);
    chk("pr_c1_mdata", mmio_data, 8'h77);
    tick();                                 // cycle 2
    mmio_done = 1'b1;
    tick();                                 // cycle 3
    mmio_done = 1'b0; cpu_req = 1'b0;
    chk("pr_c3_ready", cpu_ready, 1);
    chk("pr_c3_err", cpu_err, 0);
    tick();
    chk("pr_c4_busy", cpu_busy, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
